// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: checkpoint ids, resolved-branch records,
// the recovery FSM state and the wrapping checkpoint-age helper.
package branch_resolver_pkg;

  localparam int NUM_CHECKPOINTS  = 8;
  localparam int NUM_BR           = 2;
  localparam int PC_W             = 32;
  localparam int DEF_DRAIN_CYCLES = 2;
  localparam int CPW              = $clog2(NUM_CHECKPOINTS);

  typedef logic [CPW-1:0]  cp_id_t;
  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    logic   valid;
    cp_id_t cp_id;
    logic   mispredict;
    pc_t    target;
  } br_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECALL,
    ST_DRAIN
  } rs_state_e;

  // Distance from the oldest live checkpoint; wraps modulo NUM_CHECKPOINTS.
  function automatic cp_id_t cp_age(cp_id_t id, cp_id_t oldest);
    return id - oldest;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Branch-completion bus: execute/checkpointer side is master, the resolver is slave.
interface branch_resolver_if
  import branch_resolver_pkg::*;
();

  logic   [NUM_BR-1:0] br_valid;
  cp_id_t [NUM_BR-1:0] br_cp_id;
  logic   [NUM_BR-1:0] br_mispredict;
  pc_t    [NUM_BR-1:0] br_target;
  cp_id_t              cp_oldest_id;
  logic                no_checkpoints;

  logic   [NUM_BR-1:0] validate;
  cp_id_t [NUM_BR-1:0] validated_id;
  logic                recall_checkpoint;
  cp_id_t              recall_id;
  logic                redirect_valid;
  pc_t                 redirect_pc;
  logic                flush;
  logic                recover_busy;

  modport master (
    output br_valid, br_cp_id, br_mispredict, br_target, cp_oldest_id, no_checkpoints,
    input  validate, validated_id, recall_checkpoint, recall_id,
           redirect_valid, redirect_pc, flush, recover_busy
  );

  modport slave (
    input  br_valid, br_cp_id, br_mispredict, br_target, cp_oldest_id, no_checkpoints,
    output validate, validated_id, recall_checkpoint, recall_id,
           redirect_valid, redirect_pc, flush, recover_busy
  );

endinterface

// File: rtl/branch_resolver_cp_age_select.sv
// Combinational oldest-candidate picker over checkpoint ages; ties go to the
// lower lane index. Also exports every lane's age for ordering checks.
module cp_age_select
  import branch_resolver_pkg::*;
#(
  parameter  int LANES = NUM_BR,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic   [LANES-1:0] cand_i,
  input  cp_id_t [LANES-1:0] id_i,
  input  cp_id_t             oldest_id_i,
  output cp_id_t [LANES-1:0] age_o,
  output logic               found_o,
  output logic   [LW-1:0]    lane_o,
  output cp_id_t             min_age_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    age_o     = '0;
    found_o   = 1'b0;
    lane_o    = '0;
    min_age_o = '0;
    for (int i = 0; i < LANES; i++) begin
      age_o[i] = cp_age(id_i[i], oldest_id_i);
      // Strict compare keeps the earlier lane on equal ages.
      if (cand_i[i] && (!found_o || (age_o[i] < min_age_o))) begin
        found_o   = 1'b1;
        lane_o    = LW'(i);
        min_age_o = age_o[i];
      end
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: validates correctly predicted checkpoints and drives one
// recall/redirect per oldest mispredict, holding flush until recovery drains.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input logic              clk,
  input logic              reset,
  branch_resolver_if.slave bus
);

  localparam int LW    = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  br_result_t [NUM_BR-1:0] lane;
  logic       [NUM_BR-1:0] cand;
  cp_id_t     [NUM_BR-1:0] lane_id;
  cp_id_t     [NUM_BR-1:0] age;
  logic                    found;
  logic       [LW-1:0]     sel;
  cp_id_t                  min_age;

  rs_state_e               state_q, state_d;
  cp_id_t                  rid_q, rid_d;
  pc_t                     rpc_q, rpc_d;
  logic       [CNT_W-1:0]  cnt_q, cnt_d;
  logic       [NUM_BR-1:0] validate_q, validate_d;
  cp_id_t     [NUM_BR-1:0] vid_q, vid_d;
  logic                    recall_q, flush_q;

  logic       [CPW:0]      limit;
  logic       [CPW:0]      thresh;
  logic                    take;

  always_comb begin
    for (int i = 0; i < NUM_BR; i++) begin
      lane[i].valid      = bus.br_valid[i] & ~bus.no_checkpoints;
      lane[i].cp_id      = bus.br_cp_id[i];
      lane[i].mispredict = bus.br_mispredict[i];
      lane[i].target     = bus.br_target[i];
      cand[i]            = lane[i].valid & lane[i].mispredict;
      lane_id[i]         = lane[i].cp_id;
    end
  end

  cp_age_select #(.LANES(NUM_BR)) u_sel (
    .cand_i      (cand),
    .id_i        (lane_id),
    .oldest_id_i (bus.cp_oldest_id),
    .age_o       (age),
    .found_o     (found),
    .lane_o      (sel),
    .min_age_o   (min_age)
  );

  always_comb begin
    state_d    = state_q;
    rid_d      = rid_q;
    rpc_d      = rpc_q;
    cnt_d      = cnt_q;
    validate_d = '0;
    vid_d      = '0;

    // Idle accepts any age; during recovery only branches older than rid survive.
    limit  = (state_q == ST_IDLE) ? (CPW + 1)'(NUM_CHECKPOINTS)
                                  : {1'b0, cp_age(rid_q, bus.cp_oldest_id)};
    take   = found && ({1'b0, min_age} < limit);
    thresh = take ? {1'b0, min_age} : limit;

    for (int i = 0; i < NUM_BR; i++) begin
      if (lane[i].valid && !lane[i].mispredict && ({1'b0, age[i]} < thresh)) begin
        validate_d[i] = 1'b1;
        vid_d[i]      = lane[i].cp_id;
      end
    end

    unique case (state_q)
      ST_IDLE: ;
      ST_RECALL: begin
        state_d = ST_DRAIN;
        cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // An older mispredict always (re)starts recovery, overriding the drain.
    if (take) begin
      state_d = ST_RECALL;
      rid_d   = lane[sel].cp_id;
      rpc_d   = lane[sel].target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rid_q      <= '0;
      rpc_q      <= '0;
      cnt_q      <= '0;
      validate_q <= '0;
      vid_q      <= '0;
      recall_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      rid_q      <= rid_d;
      rpc_q      <= rpc_d;
      cnt_q      <= cnt_d;
      validate_q <= validate_d;
      vid_q      <= vid_d;
      recall_q   <= (state_d == ST_RECALL);
      flush_q    <= (state_d != ST_IDLE);
    end
  end

  assign bus.validate          = validate_q;
  assign bus.validated_id      = vid_q;
  assign bus.recall_checkpoint = recall_q;
  assign bus.recall_id         = rid_q;
  assign bus.redirect_valid    = recall_q;
  assign bus.redirect_pc       = rpc_q;
  assign bus.flush             = flush_q;
  assign bus.recover_busy      = flush_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: vector table plus recovery sequences,
// with expected outputs queued at drive time and compared one cycle later.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  typedef struct {
    logic       reset;
    logic [1:0] valid;
    logic [1:0] mis;
    cp_id_t     id0, id1;
    pc_t        t0, t1;
    cp_id_t     oldest;
    logic       nocp;
  } in_t;

  typedef struct {
    logic [1:0] val;
    cp_id_t     vid0, vid1;
    logic       recall;
    cp_id_t     rid;
    pc_t        rpc;
    logic       flush;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  exp_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[10];

  branch_resolver_if bus ();

  branch_resolver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk_in(logic [1:0] valid, logic [1:0] mis, cp_id_t id0, cp_id_t id1,
                                pc_t t0, pc_t t1, cp_id_t oldest, logic nocp);
    in_t r;
    r.reset = 1'b0; r.valid = valid; r.mis = mis; r.id0 = id0; r.id1 = id1;
    r.t0 = t0; r.t1 = t1; r.oldest = oldest; r.nocp = nocp;
    return r;
  endfunction

  function automatic in_t rst_in();
    in_t r;
    r = mk_in(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 3'd0, 1'b0);
    r.reset = 1'b1;
    return r;
  endfunction

  function automatic in_t idle_in(cp_id_t oldest);
    return mk_in(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, oldest, 1'b0);
  endfunction

  function automatic exp_t mk_exp(logic [1:0] val, cp_id_t vid0, cp_id_t vid1, logic recall,
                                  cp_id_t rid, pc_t rpc, logic flush);
    exp_t e;
    e.val = val; e.vid0 = vid0; e.vid1 = vid1; e.recall = recall;
    e.rid = rid; e.rpc = rpc; e.flush = flush;
    return e;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic apply(in_t i);
    reset                  = i.reset;
    bus.br_valid           = i.valid;
    bus.br_mispredict      = i.mis;
    bus.br_cp_id[0]        = i.id0;
    bus.br_cp_id[1]        = i.id1;
    bus.br_target[0]       = i.t0;
    bus.br_target[1]       = i.t1;
    bus.cp_oldest_id       = i.oldest;
    bus.no_checkpoints     = i.nocp;
  endtask

  task automatic compare_front();
    exp_t  e;
    string nm;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    check({nm, ".validate"},       32'(bus.validate),          32'(e.val));
    check({nm, ".validated_id0"},  32'(bus.validated_id[0]),   32'(e.vid0));
    check({nm, ".validated_id1"},  32'(bus.validated_id[1]),   32'(e.vid1));
    check({nm, ".recall"},         32'(bus.recall_checkpoint), 32'(e.recall));
    check({nm, ".redirect_valid"}, 32'(bus.redirect_valid),    32'(e.recall));
    check({nm, ".recall_id"},      32'(bus.recall_id),         32'(e.rid));
    check({nm, ".redirect_pc"},    bus.redirect_pc,            e.rpc);
    check({nm, ".flush"},          32'(bus.flush),             32'(e.flush));
    check({nm, ".recover_busy"},   32'(bus.recover_busy),      32'(e.flush));
  endtask

  // Drive at the falling edge, let the rising edge register, compare at the next falling edge.
  task automatic step(string nm, in_t i, exp_t e);
    apply(i);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    compare_front();
  endtask

  initial begin
    exp_t zero;
    zero = mk_exp(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'h0, 1'b0);

    vecs[0] = '{"single_correct",
      mk_in(2'b01, 2'b00, 3'd3, 3'd0, 32'h0, 32'h0, 3'd0, 1'b0),
      mk_exp(2'b01, 3'd3, 3'd0, 1'b0, 3'd0, 32'h0, 1'b0)};
    vecs[1] = '{"oldest_on_lane1",
      mk_in(2'b11, 2'b11, 3'd5, 3'd2, 32'h100, 32'h200, 3'd0, 1'b0),
      mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd2, 32'h200, 1'b1)};
    vecs[2] = '{"wrap_age",
      mk_in(2'b11, 2'b01, 3'd1, 3'd7, 32'h300, 32'h0, 3'd6, 1'b0),
      mk_exp(2'b10, 3'd0, 3'd7, 1'b1, 3'd1, 32'h300, 1'b1)};
    vecs[3] = '{"younger_correct_dropped",
      mk_in(2'b11, 2'b01, 3'd4, 3'd6, 32'h400, 32'h0, 3'd2, 1'b0),
      mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd4, 32'h400, 1'b1)};
    vecs[4] = '{"no_checkpoints",
      mk_in(2'b11, 2'b10, 3'd1, 3'd2, 32'h0, 32'h440, 3'd0, 1'b1),
      mk_exp(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'h0, 1'b0)};
    vecs[5] = '{"tie_lower_lane",
      mk_in(2'b11, 2'b11, 3'd3, 3'd3, 32'h500, 32'h600, 3'd0, 1'b0),
      mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd3, 32'h500, 1'b1)};
    vecs[6] = '{"duplicate_validate",
      mk_in(2'b11, 2'b00, 3'd2, 3'd2, 32'h0, 32'h0, 3'd1, 1'b0),
      mk_exp(2'b11, 3'd2, 3'd2, 1'b0, 3'd0, 32'h0, 1'b0)};
    vecs[7] = '{"correct_shares_rid",
      mk_in(2'b11, 2'b10, 3'd5, 3'd5, 32'h0, 32'h700, 3'd0, 1'b0),
      mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd5, 32'h700, 1'b1)};
    vecs[8] = '{"invalid_lane_ignored",
      mk_in(2'b01, 2'b10, 3'd4, 3'd1, 32'h0, 32'h99, 3'd0, 1'b0),
      mk_exp(2'b01, 3'd4, 3'd0, 1'b0, 3'd0, 32'h0, 1'b0)};
    vecs[9] = '{"oldest_on_lane0_wrap",
      mk_in(2'b11, 2'b11, 3'd7, 3'd4, 32'h800, 32'h880, 3'd5, 1'b0),
      mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd7, 32'h800, 1'b1)};

    apply(rst_in());
    @(negedge clk);
    step("reset_state", rst_in(), zero);

    for (int k = 0; k < 10; k++) begin
      step("reset", rst_in(), zero);
      step(vecs[k].name, vecs[k].in, vecs[k].exp);
      if (vecs[k].exp.recall) begin
        // One recall cycle is followed by two drain cycles, then the window closes.
        step({vecs[k].name, "_drain1"}, idle_in(vecs[k].in.oldest),
             mk_exp(2'b00, 3'd0, 3'd0, 1'b0, vecs[k].exp.rid, vecs[k].exp.rpc, 1'b1));
        step({vecs[k].name, "_drain2"}, idle_in(vecs[k].in.oldest),
             mk_exp(2'b00, 3'd0, 3'd0, 1'b0, vecs[k].exp.rid, vecs[k].exp.rpc, 1'b1));
        step({vecs[k].name, "_done"}, idle_in(vecs[k].in.oldest),
             mk_exp(2'b00, 3'd0, 3'd0, 1'b0, vecs[k].exp.rid, vecs[k].exp.rpc, 1'b0));
      end
    end

    // Older mispredict during drain re-enters recall; a younger one is squashed.
    step("ovr_reset", rst_in(), zero);
    step("ovr_first", mk_in(2'b01, 2'b01, 3'd5, 3'd0, 32'h50, 32'h0, 3'd0, 1'b0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd5, 32'h50, 1'b1));
    step("ovr_drain", idle_in(3'd0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b0, 3'd5, 32'h50, 1'b1));
    step("ovr_second", mk_in(2'b11, 2'b11, 3'd3, 3'd6, 32'h40, 32'h60, 3'd0, 1'b0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd3, 32'h40, 1'b1));
    step("ovr_squash", mk_in(2'b11, 2'b01, 3'd6, 3'd1, 32'h66, 32'h0, 3'd0, 1'b0),
         mk_exp(2'b10, 3'd0, 3'd1, 1'b0, 3'd3, 32'h40, 1'b1));
    step("ovr_drain2", idle_in(3'd0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b0, 3'd3, 32'h40, 1'b1));
    step("ovr_done", idle_in(3'd0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b0, 3'd3, 32'h40, 1'b0));

    // Back-to-back recalls when the override lands in the recall cycle itself.
    step("b2b_reset", rst_in(), zero);
    step("b2b_first", mk_in(2'b01, 2'b01, 3'd4, 3'd0, 32'h90, 32'h0, 3'd0, 1'b0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd4, 32'h90, 1'b1));
    step("b2b_second", mk_in(2'b10, 2'b10, 3'd0, 3'd1, 32'h0, 32'hA0, 3'd0, 1'b0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd1, 32'hA0, 1'b1));
    step("b2b_drain1", idle_in(3'd0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b0, 3'd1, 32'hA0, 1'b1));
    step("b2b_drain2", idle_in(3'd0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b0, 3'd1, 32'hA0, 1'b1));
    step("b2b_done", idle_in(3'd0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b0, 3'd1, 32'hA0, 1'b0));

    // Reset in the recall cycle aborts recovery outright.
    step("abort_reset0", rst_in(), zero);
    step("abort_recall", mk_in(2'b01, 2'b01, 3'd2, 3'd0, 32'h90, 32'h0, 3'd0, 1'b0),
         mk_exp(2'b00, 3'd0, 3'd0, 1'b1, 3'd2, 32'h90, 1'b1));
    step("abort_reset", rst_in(), zero);
    step("abort_idle", idle_in(3'd0), zero);
    step("abort_nocp", mk_in(2'b11, 2'b01, 3'd1, 3'd2, 32'h10, 32'h0, 3'd0, 1'b1), zero);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Producer side of the checkpoint validate/recall interface, on the branch-completion path.
- Takes up to NUM_BR resolved branches per cycle from the execute stage. Each carries a checkpoint id, a mispredict flag and a correct target.
- For correctly predicted branches it issues validate/validated_id. For the oldest mispredict it issues a one-cycle recall to the checkpointer, redirects fetch and holds a flush/stall window until recovery completes.

Parameters:
NUM_CHECKPOINTS, `NUM_CHECKPOINTS (8), checkpoint slots; power of two
NUM_BR, `NUM_BRANCHES_RESOLVED (2), branch resolution lanes per cycle
PC_W, 32, program counter width
DRAIN_CYCLES, 2, flush cycles after the recall cycle; must be >= 1
(CPW = $clog2(NUM_CHECKPOINTS) throughout)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
br_valid  in  [NUM_BR] x 1  lane carries a resolved branch
br_cp_id  in  [NUM_BR] x CPW  checkpoint id allocated to the branch
br_mispredict  in  [NUM_BR] x 1  prediction was wrong
br_target  in  [NUM_BR] x PC_W  correct next PC
cp_oldest_id  in  CPW  oldest live checkpoint id (checkpointer back pointer)
no_checkpoints  in  1  checkpointer holds no live checkpoint
validate  out  [NUM_BR] x 1  registered; checkpoint may retire
validated_id  out  [NUM_BR] x CPW  registered id per validate lane
recall_checkpoint  out  1  registered; one-cycle restore request
recall_id  out  CPW  checkpoint to restore; held stable during recovery
redirect_valid  out  1  one-cycle fetch redirect, coincident with recall
redirect_pc  out  PC_W  target of the recovering branch
flush  out  1  kill younger in-flight instructions
recover_busy  out  1  stall fetch/rename (OR into ext_stall)

Behaviour:
- Single clock, synchronous active-high reset.
- Reset values: state IDLE; all outputs 0.
- Reset during recovery aborts it: no further recall next cycle.
- Age:
  - age(id) = (id - cp_oldest_id) mod NUM_CHECKPOINTS, a CPW-bit wrapping subtract.
  - Smaller age is older.
  - Wrap case: oldest=6, id=1 gives age 3.
- Lanes are ignored when br_valid=0 or no_checkpoints=1.
- Selection (combinational, every cycle): candidate = valid mispredict lane with the smallest age. On a tie, the lower lane index wins.
- Outputs are registered, so all responses appear 1 cycle after the input cycle.
- FSM states:
  - IDLE:
    - Candidate exists: latch rid=id and rpc=target, go to RECALL.
    - In the same cycle, correct lanes with age < age(rid) produce validate next cycle.
    - Lanes with age >= age(rid) are dropped, including a correct lane sharing rid.
    - No candidate: every valid correct lane validates.
  - RECALL (exactly 1 cycle):
    - recall_checkpoint=1, redirect_valid=1, flush=1, recover_busy=1.
    - Then DRAIN with cnt=DRAIN_CYCLES-1.
  - DRAIN:
    - flush=1, recover_busy=1; decrement cnt.
    - At cnt==0 go to IDLE.
- Resolutions arriving during RECALL/DRAIN:
  - Correct lane with age < age(rid): validated.
  - Mispredict lane with age < age(rid): overrides. Re-latch rid/rpc and re-enter RECALL, issuing a second recall and redirect.
  - Everything else is dropped as squashed.
- validated_id is never equal to a pending or just-issued rid.
- At most one recall pulse per cycle. recall_id and redirect_pc stay stable from RECALL until the next latch.
- validate lanes are independent. Two lanes with the same id may both assert; the checkpointer tolerates duplicates.

Decomposition:
- Shared package (riscv_core pkg/svh): CPW-based cp_id_t; the br_result_t struct {valid, cp_id, mispredict, target}; the resolver state enum.
- One sub-module, cp_age_select: combinational oldest-mispredict picker (ages, min-reduce, tie-break). Reusable by the LSU for memory-order recovery.

Test Plan:
- Reset, then lane0 valid id=3 correct, oldest=0 -> next cycle validate[0]=1, validated_id[0]=3; recall_checkpoint=0.
- Lane0 id=5 mispredict target=0x100, lane1 id=2 mispredict target=0x200, oldest=0 -> recall_id=2, redirect_pc=0x200, one pulse; flush high 1+DRAIN_CYCLES=3 cycles; recover_busy low on cycle 4.
- Wrap: oldest=6, lane0 id=1 mispredict, lane1 id=7 correct -> validate[1] id=7 and recall_id=1 in the same cycle.
- Lane0 id=4 mispredict, lane1 id=6 correct, oldest=2 -> recall_id=4; lane1 dropped (validate[1]=0).
- During DRAIN with rid=5, oldest=0: mispredict id=3 target=0x40 -> second recall, recall_id=3, redirect_pc=0x40, flush extended 3 more cycles. Mispredict id=6 during DRAIN -> ignored.
- Reset asserted during RECALL -> next cycle all outputs 0, state IDLE; no_checkpoints=1 with valid lanes -> no outputs.
